// File: rtl/oven_controller.sv
// Oven sequencer: power, setpoint, preheat, timed bake and done, with a
// tick-driven thermal model standing in for the real cavity temperature.
//
// state   | meaning
// --------+----------------------------------------------------------
// OFF     | powered down, heater off, keys other than on/off ignored
// IDLE    | powered, setpoint adjustable, waiting for start
// PREHEAT | heater forced on until within HYST of the setpoint
// BAKE    | bang-bang regulation, time_left counts down once per tick
// DONE    | bake finished, done high, start returns to IDLE

module oven_controller #(
    parameter int TICK_DIV     = 50000000,
    parameter int TEMP_DEFAULT = 350,
    parameter int TEMP_MIN     = 150,
    parameter int TEMP_MAX     = 550,
    parameter int TEMP_STEP    = 5,
    parameter int AMBIENT      = 70,
    parameter int HEAT_RATE    = 2,
    parameter int COOL_RATE    = 1,
    parameter int HYST         = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_onoff_n,
    input  logic        key_up_n,
    input  logic        key_down_n,
    input  logic        key_start_n,
    input  logic [12:0] bake_time,
    output logic [2:0]  state,
    output logic        heater_on,
    output logic [9:0]  target_temp,
    output logic [9:0]  cur_temp,
    output logic [12:0] time_left,
    output logic        done,
    output logic        tick
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_IDLE    = 3'd1,
        S_PREHEAT = 3'd2,
        S_BAKE    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [9:0]  T_DEF  = 10'(TEMP_DEFAULT);
    localparam logic [9:0]  T_MIN  = 10'(TEMP_MIN);
    localparam logic [9:0]  T_MAX  = 10'(TEMP_MAX);
    localparam logic [9:0]  T_STEP = 10'(TEMP_STEP);
    localparam logic [9:0]  T_AMB  = 10'(AMBIENT);
    localparam logic [9:0]  T_COOL = 10'(COOL_RATE);
    localparam logic [9:0]  T_HYST = 10'(HYST);
    localparam logic [10:0] T_HEAT = 11'(HEAT_RATE);
    localparam logic [10:0] T_CEIL = 11'd1023;

    state_t           state_q, state_d;
    logic             heater_q, heater_d;
    logic [9:0]       target_q, target_d;
    logic [9:0]       cur_q, cur_d;
    logic [12:0]      time_q, time_d;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]       key_s1, key_s2, key_prev;
    logic [3:0]       press;
    logic             p_onoff, p_start, p_up, p_down;

    logic [10:0]      heat_sum;
    logic [9:0]       cur_hot, cur_cool;
    logic [9:0]       reg_low;
    logic             adj_state;

    // Key order in the synchroniser vectors: {onoff, start, up, down}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= 4'b1111;
            key_s2   <= 4'b1111;
            key_prev <= 4'b1111;
        end else begin
            key_s1   <= {key_onoff_n, key_start_n, key_up_n, key_down_n};
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    assign press = key_prev & ~key_s2;
    assign {p_onoff, p_start, p_up, p_down} = press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    assign heat_sum  = {1'b0, cur_q} + T_HEAT;
    assign cur_hot   = (heat_sum > T_CEIL) ? 10'd1023 : heat_sum[9:0];
    assign cur_cool  = (cur_q < T_AMB + T_COOL) ? T_AMB : cur_q - T_COOL;
    // Setpoint never goes below TEMP_MIN, so this cannot underflow for sane HYST.
    assign reg_low   = target_q - T_HYST;
    assign adj_state = (state_q == S_IDLE) || (state_q == S_PREHEAT) || (state_q == S_BAKE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            heater_q <= 1'b0;
            target_q <= T_DEF;
            cur_q    <= T_AMB;
            time_q   <= '0;
        end else begin
            state_q  <= state_d;
            heater_q <= heater_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            time_q   <= time_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        heater_d = heater_q;
        target_d = target_q;
        cur_d    = cur_q;
        time_d   = time_q;

        // Thermal step uses the heater level that was in force during the tick.
        if (tick) begin
            cur_d = heater_q ? cur_hot : cur_cool;
        end

        if (adj_state && !p_onoff && !p_start && (p_up ^ p_down)) begin
            if (p_up) begin
                target_d = (target_q > T_MAX - T_STEP) ? T_MAX : target_q + T_STEP;
            end else begin
                target_d = (target_q < T_MIN + T_STEP) ? T_MIN : target_q - T_STEP;
            end
        end

        case (state_q)
            S_OFF: begin
                heater_d = 1'b0;
                if (p_onoff) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                heater_d = 1'b0;
                if (p_start) begin
                    state_d  = S_PREHEAT;
                    heater_d = 1'b1;
                end
            end
            S_PREHEAT: begin
                heater_d = 1'b1;
                if (cur_q >= reg_low) begin
                    state_d = S_BAKE;
                    time_d  = bake_time;
                end
            end
            S_BAKE: begin
                if (cur_q < reg_low) begin
                    heater_d = 1'b1;
                end else if (cur_q >= target_q) begin
                    heater_d = 1'b0;
                end
                if (tick) begin
                    if (time_q == '0) begin
                        state_d  = S_DONE;
                        heater_d = 1'b0;
                    end else begin
                        time_d = time_q - 13'd1;
                    end
                end
            end
            S_DONE: begin
                heater_d = 1'b0;
                if (p_start) begin
                    state_d = S_IDLE;
                    time_d  = '0;
                end
            end
            default: begin
                state_d  = S_OFF;
                heater_d = 1'b0;
                time_d   = '0;
            end
        endcase

        // Power key overrides everything else from any powered state.
        if (p_onoff && (state_q != S_OFF)) begin
            state_d  = S_OFF;
            heater_d = 1'b0;
            time_d   = '0;
        end
    end

    assign state       = state_q;
    assign heater_on   = heater_q;
    assign target_temp = target_q;
    assign cur_temp    = cur_q;
    assign time_left   = time_q;
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_oven_controller.sv
// Bench for oven_controller: directed key sequences push expected values into
// a queue; a monitor process drains it at each falling clock edge.

module tb_oven_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_onoff_n = 1'b1;
    logic        key_up_n = 1'b1;
    logic        key_down_n = 1'b1;
    logic        key_start_n = 1'b1;
    logic [12:0] bake_time = 13'd0;
    logic [2:0]  state;
    logic        heater_on;
    logic [9:0]  target_temp;
    logic [9:0]  cur_temp;
    logic [12:0] time_left;
    logic        done;
    logic        tick;

    always #5 clk = ~clk;

    oven_controller #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_onoff_n (key_onoff_n),
        .key_up_n    (key_up_n),
        .key_down_n  (key_down_n),
        .key_start_n (key_start_n),
        .bake_time   (bake_time),
        .state       (state),
        .heater_on   (heater_on),
        .target_temp (target_temp),
        .cur_temp    (cur_temp),
        .time_left   (time_left),
        .done        (done),
        .tick        (tick)
    );

    localparam int SEL_STATE = 0, SEL_HEAT = 1, SEL_TGT = 2, SEL_CUR = 3;
    localparam int SEL_TL = 4, SEL_DONE = 5, SEL_TICK = 6, SEL_TOG = 7;
    localparam logic [3:0] K_ONOFF = 4'b1000, K_START = 4'b0100;
    localparam logic [3:0] K_UP = 4'b0010, K_DOWN = 4'b0001;

    typedef struct {
        string name;
        int    sel;
        int    lo;
        int    hi;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   heater_toggles = 0;
    int   tog_base = 0;

    function automatic int observe(input int sel);
        case (sel)
            SEL_STATE: return int'(state);
            SEL_HEAT:  return int'(heater_on);
            SEL_TGT:   return int'(target_temp);
            SEL_CUR:   return int'(cur_temp);
            SEL_TL:    return int'(time_left);
            SEL_DONE:  return int'(done);
            SEL_TICK:  return int'(tick);
            default:   return heater_toggles - tog_base;
        endcase
    endfunction

    task automatic expect_range(input string n, input int sel, input int lo, input int hi);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    task automatic expect_eq(input string n, input int sel, input int v);
        expect_range(n, sel, v, v);
    endtask

    // Monitor: drains the scoreboard, checks tick spacing, tracks heater toggles.
    initial begin
        exp_t e;
        int   a;
        int   since_tick;
        logic heater_prev;
        since_tick  = -1;
        heater_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = observe(e.sel);
                total++;
                if (a < e.lo || a > e.hi) begin
                    bad++;
                    $display("FAIL %s: got %0d, want %0d..%0d", e.name, a, e.lo, e.hi);
                end
            end
            if (!rst_n) begin
                since_tick = -1;
            end else begin
                if (since_tick >= 0) since_tick++;
                if (tick) begin
                    if (since_tick >= 0) begin
                        total++;
                        if (since_tick != 4) begin
                            bad++;
                            $display("FAIL tick_period: got %0d clk, want 4", since_tick);
                        end
                    end
                    since_tick = 0;
                end
                if (heater_on !== heater_prev) heater_toggles++;
            end
            heater_prev = heater_on;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Keys mask order {onoff, start, up, down}; returns with all keys released
    // long enough for the synchroniser to settle.
    task automatic press(input logic [3:0] m);
        {key_onoff_n, key_start_n, key_up_n, key_down_n} = ~m;
        repeat (4) @(posedge clk);
        #1;
        {key_onoff_n, key_start_n, key_up_n, key_down_n} = 4'b1111;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string n, input int s, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (int'(state) == s) break;
        end
        expect_eq(n, SEL_STATE, s);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tick) break;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        expect_eq("rst_state", SEL_STATE, 0);
        expect_eq("rst_cur", SEL_CUR, 70);
        expect_eq("rst_target", SEL_TGT, 350);
        expect_eq("rst_heater", SEL_HEAT, 0);
        expect_eq("rst_time_left", SEL_TL, 0);
        expect_eq("rst_done", SEL_DONE, 0);

        press(K_UP);
        expect_eq("off_ignores_up", SEL_TGT, 350);
        press(K_ONOFF);
        expect_eq("onoff_to_idle", SEL_STATE, 1);

        for (int i = 0; i < 40; i++) press(K_UP);
        expect_eq("up_reach_max", SEL_TGT, 550);
        for (int i = 0; i < 10; i++) press(K_UP);
        expect_eq("up_saturate", SEL_TGT, 550);
        for (int i = 0; i < 100; i++) press(K_DOWN);
        expect_eq("down_saturate", SEL_TGT, 150);
        press(K_UP);
        expect_eq("up_one_step", SEL_TGT, 155);
        press(K_UP | K_DOWN);
        expect_eq("up_down_ignored", SEL_TGT, 155);
        press(K_DOWN);
        press(K_DOWN);
        expect_eq("down_floor", SEL_TGT, 150);

        // Preheat from 70 to 148 (target-HYST), then bake 3 s.
        bake_time = 13'd3;
        press(K_START);
        expect_eq("preheat_state", SEL_STATE, 2);
        expect_eq("preheat_heater", SEL_HEAT, 1);
        wait_state("preheat_to_bake", 3, 400);
        expect_eq("bake_entry_cur", SEL_CUR, 148);
        expect_eq("bake_entry_tl", SEL_TL, 3);
        expect_eq("bake_entry_heater", SEL_HEAT, 1);
        wait_tick();
        expect_eq("bake_t1_tl", SEL_TL, 2);
        expect_eq("bake_t1_cur", SEL_CUR, 150);
        wait_tick();
        expect_eq("bake_t2_tl", SEL_TL, 1);
        expect_eq("bake_t2_cur", SEL_CUR, 149);
        expect_eq("bake_t2_heater", SEL_HEAT, 0);
        wait_tick();
        expect_eq("bake_t3_tl", SEL_TL, 0);
        expect_eq("bake_t3_state", SEL_STATE, 3);
        wait_tick();
        expect_eq("done_state", SEL_STATE, 4);
        expect_eq("done_flag", SEL_DONE, 1);
        expect_eq("done_heater", SEL_HEAT, 0);
        expect_eq("done_cur", SEL_CUR, 147);

        press(K_START);
        expect_eq("done_to_idle", SEL_STATE, 1);
        expect_eq("idle_done_low", SEL_DONE, 0);
        expect_eq("idle_tl", SEL_TL, 0);

        key_up_n = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        key_up_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        expect_eq("hold_one_step", SEL_TGT, 155);
        press(K_DOWN);
        expect_eq("back_to_150", SEL_TGT, 150);

        // Regulation: band is target-3..target+1 given +2/-1 steps.
        bake_time = 13'd100;
        press(K_START);
        wait_state("reg_to_bake", 3, 400);
        tog_base = heater_toggles;
        for (int i = 0; i < 40; i++) begin
            wait_tick();
            expect_range("reg_band", SEL_CUR, 147, 151);
        end
        expect_eq("reg_tl_after_40", SEL_TL, 60);
        expect_range("reg_heater_toggles", SEL_TOG, 4, 1000);

        key_onoff_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("onoff_before_edge", SEL_STATE, 3);
        @(posedge clk);
        #1;
        expect_eq("onoff_state_off", SEL_STATE, 0);
        expect_eq("onoff_heater_off", SEL_HEAT, 0);
        expect_eq("onoff_tl_zero", SEL_TL, 0);
        key_onoff_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        press(K_ONOFF);
        press(K_START);
        wait_state("rst_run_bake", 3, 400);
        wait_tick();
        wait_tick();
        #2;
        rst_n = 1'b0;
        expect_eq("async_state", SEL_STATE, 0);
        expect_eq("async_heater", SEL_HEAT, 0);
        expect_eq("async_target", SEL_TGT, 350);
        expect_eq("async_cur", SEL_CUR, 70);
        expect_eq("async_tl", SEL_TL, 0);
        expect_eq("async_done", SEL_DONE, 0);
        expect_eq("async_tick", SEL_TICK, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        expect_eq("post_rst_state", SEL_STATE, 0);
        expect_eq("post_rst_done", SEL_DONE, 0);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
